// File: rtl/ncl_seq_pkg.sv
// ncl_seq_pkg: command encodings, FSM states and rail helpers
// shared by the NCL counter sequencer.
package ncl_seq_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        OP_COUNT = 2'b00,
        OP_HOLD  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } cmd_op_t;

    typedef enum logic [1:0] {
        IN_IDLE,
        IN_DATA,
        IN_NULL
    } in_state_t;

    typedef enum logic {
        OUT_WAIT_DATA,
        OUT_WAIT_NULL
    } out_state_t;

    typedef struct packed {
        logic t_clr;
        logic f_clr;
        logic t_enable;
        logic f_enable;
    } rails_t;

    // DATA wavefront for an op: exactly one rail of each pair high.
    function automatic rails_t op_rails(input logic [1:0] op);
        rails_t r;
        r = '0;
        case (op)
            OP_COUNT: begin
                r.t_enable = 1'b1;
                r.f_clr    = 1'b1;
            end
            OP_HOLD: begin
                r.f_enable = 1'b1;
                r.f_clr    = 1'b1;
            end
            OP_CLEAR: begin
                r.t_enable = 1'b1;
                r.t_clr    = 1'b1;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ncl_counter_sequencer_sync.sv
// ncl_sync: parameterized-width multi-flop synchronizer
// for signals crossing in from the asynchronous NCL counter.
module ncl_sync
    import ncl_seq_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [STAGES];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/ncl_counter_sequencer.sv
// ncl_counter_sequencer: issues dual-rail command tokens to an NCL
// counter and captures its dual-rail results under a watchdog.
module ncl_counter_sequencer
    import ncl_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TIMEOUT  = 1024,
    parameter int RST_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [8:0]       cmd_len,
    output logic             ncl_reset_n,
    output logic             f_clr,
    output logic             t_clr,
    output logic             f_enable,
    output logic             t_enable,
    input  logic             ackout,
    output logic             ackin,
    input  logic [WIDTH-1:0] f_out,
    input  logic [WIDTH-1:0] t_out,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(RST_HOLD + 1) + 1;

    logic             ack_s;
    logic [WIDTH-1:0] t_s;
    logic [WIDTH-1:0] f_s;

    ncl_sync #(.WIDTH(1)) u_sync_ack (
        .clk   (clk),
        .reset (reset),
        .d     (ackout),
        .q     (ack_s)
    );

    ncl_sync #(.WIDTH(2*WIDTH)) u_sync_out (
        .clk   (clk),
        .reset (reset),
        .d     ({t_out, f_out}),
        .q     ({t_s, f_s})
    );

    in_state_t  in_state;
    in_state_t  in_next;
    out_state_t out_state;
    out_state_t out_next;

    logic [1:0]    op_q;
    logic [8:0]    len_q;
    logic [8:0]    iss_cnt;
    logic [8:0]    iss_next;
    logic [8:0]    cap_cnt;
    logic [TW-1:0] in_tmr;
    logic [TW-1:0] out_tmr;
    logic [HW-1:0] hold_cnt;
    logic          data_prev;
    logic          null_prev;
    rails_t        rails_q;
    rails_t        rails_d;

    logic all_data;
    logic all_null;
    logic bad_pair;
    logic accept;
    logic legal;
    logic out_timed;
    logic in_to;
    logic out_to;
    logic err_d;
    logic cap_fire;
    logic done_d;
    logic busy_d;

    assign all_data = &(t_s ^ f_s);
    assign all_null = ~|(t_s | f_s);
    assign bad_pair = |(t_s & f_s);

    assign cmd_ready = (in_state == IN_IDLE)
                    && (out_state == OUT_WAIT_DATA)
                    && ncl_reset_n && !err && !busy;
    assign accept    = cmd_valid && cmd_ready;
    assign legal     = (cmd_op != OP_RSVD) && (cmd_len != 9'd0);
    assign out_timed = busy || (out_state == OUT_WAIT_NULL);

    always_comb begin
        in_next  = in_state;
        iss_next = iss_cnt;
        out_next = out_state;
        cap_fire = 1'b0;
        in_to    = 1'b0;
        out_to   = 1'b0;
        err_d    = err;
        done_d   = 1'b0;
        busy_d   = busy;
        rails_d  = '0;

        case (in_state)
            IN_IDLE: begin
                if (accept && legal) begin
                    in_next  = IN_DATA;
                    iss_next = 9'd1;
                end
            end
            IN_DATA: begin
                if (!ack_s) in_next = IN_NULL;
            end
            IN_NULL: begin
                if (ack_s) begin
                    if (iss_cnt < len_q) begin
                        in_next  = IN_DATA;
                        iss_next = iss_cnt + 9'd1;
                    end else begin
                        in_next = IN_IDLE;
                    end
                end
            end
            default: in_next = IN_IDLE;
        endcase

        // Two matching synced samples filter skew across the bus.
        case (out_state)
            OUT_WAIT_DATA: begin
                if (all_data && data_prev) begin
                    out_next = OUT_WAIT_NULL;
                    cap_fire = 1'b1;
                end
            end
            OUT_WAIT_NULL: begin
                if (all_null && null_prev) out_next = OUT_WAIT_DATA;
            end
            default: out_next = OUT_WAIT_DATA;
        endcase

        in_to  = (in_state != IN_IDLE) && (in_next == in_state)
              && (in_tmr == TW'(TIMEOUT - 1));
        out_to = out_timed && (out_next == out_state)
              && (out_tmr == TW'(TIMEOUT - 1));

        err_d = err || bad_pair || in_to || out_to
             || (accept && !legal);

        if (err_d) begin
            in_next  = IN_IDLE;
            out_next = OUT_WAIT_DATA;
            cap_fire = 1'b0;
        end

        done_d = busy && !err_d && (in_state == IN_IDLE)
              && (cap_cnt == len_q);

        if (err_d)       busy_d = 1'b0;
        else if (accept) busy_d = 1'b1;
        else if (done_d) busy_d = 1'b0;

        if (in_next == IN_DATA)
            rails_d = op_rails(accept ? cmd_op : op_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_state    <= IN_IDLE;
            out_state   <= OUT_WAIT_DATA;
            op_q        <= 2'b00;
            len_q       <= 9'd0;
            iss_cnt     <= 9'd0;
            cap_cnt     <= 9'd0;
            in_tmr      <= '0;
            out_tmr     <= '0;
            hold_cnt    <= '0;
            ncl_reset_n <= 1'b0;
            data_prev   <= 1'b0;
            null_prev   <= 1'b0;
            rails_q     <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            in_state  <= in_next;
            out_state <= out_next;
            iss_cnt   <= iss_next;
            rails_q   <= rails_d;
            data_prev <= all_data;
            null_prev <= all_null;
            res_valid <= cap_fire;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;

            if (cap_fire) res_data <= t_s;

            if (accept) begin
                op_q    <= cmd_op;
                len_q   <= cmd_len;
                cap_cnt <= 9'd0;
            end else if (cap_fire && busy) begin
                cap_cnt <= cap_cnt + 9'd1;
            end

            if (in_next != in_state || in_state == IN_IDLE)
                in_tmr <= '0;
            else
                in_tmr <= in_tmr + TW'(1);

            if (out_next != out_state || !out_timed)
                out_tmr <= '0;
            else
                out_tmr <= out_tmr + TW'(1);

            // Keep the counter in reset a few cycles past our own release.
            if (hold_cnt == HW'(RST_HOLD))
                ncl_reset_n <= 1'b1;
            else
                hold_cnt <= hold_cnt + HW'(1);
        end
    end

    assign t_clr    = rails_q.t_clr;
    assign f_clr    = rails_q.f_clr;
    assign t_enable = rails_q.t_enable;
    assign f_enable = rails_q.f_enable;
    assign ackin    = (out_state == OUT_WAIT_DATA);

endmodule

// File: tb/tb_ncl_counter_sequencer.sv
// tb_ncl_counter_sequencer: directed bench with a behavioural
// dual-rail NCL counter model driving the sequencer.
module tb_ncl_counter_sequencer;
    import ncl_seq_pkg::*;

    localparam int WIDTH    = 8;
    localparam int TIMEOUT  = 40;
    localparam int RST_HOLD = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [8:0]       cmd_len = 9'd0;
    logic             ncl_reset_n;
    logic             f_clr;
    logic             t_clr;
    logic             f_enable;
    logic             t_enable;
    logic             ackout = 1'b1;
    logic             ackin;
    logic [WIDTH-1:0] f_out = '0;
    logic [WIDTH-1:0] t_out = '0;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             busy;
    logic             done;
    logic             err;

    int tests = 0;
    int fails = 0;

    logic [7:0] val = 8'd0;
    bit         fault_mode = 1'b0;
    bit         nodrop_mode = 1'b0;
    logic [7:0] resq[$];
    int         done_cnt = 0;
    int         low_cycles;
    int         bad;
    int         n;

    logic in_data;
    logic in_null;
    logic [3:0] rails;

    assign in_data = (t_clr ^ f_clr) && (t_enable ^ f_enable);
    assign in_null = !(t_clr | f_clr | t_enable | f_enable);
    assign rails   = {t_clr, f_clr, t_enable, f_enable};

    ncl_counter_sequencer #(
        .WIDTH    (WIDTH),
        .TIMEOUT  (TIMEOUT),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_len     (cmd_len),
        .ncl_reset_n (ncl_reset_n),
        .f_clr       (f_clr),
        .t_clr       (t_clr),
        .f_enable    (f_enable),
        .t_enable    (t_enable),
        .ackout      (ackout),
        .ackin       (ackin),
        .f_out       (f_out),
        .t_out       (t_out),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Counter model: responds on the falling edge, away from DUT sampling.
    always @(negedge clk) begin
        if (!ncl_reset_n) begin
            ackout = 1'b1;
            t_out  = '0;
            f_out  = '0;
            val    = 8'd0;
        end else if (!nodrop_mode && in_data && ackout && ackin
                     && t_out == '0 && f_out == '0) begin
            if (t_clr)         val = 8'd0;
            else if (t_enable) val = val + 8'd1;
            t_out = val;
            f_out = ~val;
            if (fault_mode) begin
                t_out[3] = 1'b1;
                f_out[3] = 1'b1;
            end
            ackout = 1'b0;
        end else if (in_null && !ackout && !ackin) begin
            t_out  = '0;
            f_out  = '0;
            ackout = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (res_valid) resq.push_back(res_data);
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic release_reset(output int lows);
        reset = 1'b1;
        lows  = 0;
        for (int i = 0; i < RST_HOLD + 10; i++) begin
            @(negedge clk);
            if (ncl_reset_n) break;
            lows++;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [8:0] len);
        bit ok;
        ok        = 1'b0;
        cmd_op    = op;
        cmd_len   = len;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1 cmd_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done_cnt == 0 && k < 20000) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [8:0] len);
        resq.delete();
        done_cnt = 0;
        @(negedge clk);
        issue(op, len);
        wait_done();
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) break;
            @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_ncl_reset_n", ncl_reset_n, 0);
        check("rst_ackin", ackin, 1);
        check("rst_rails", rails, 0);
        check("rst_res", {res_valid, res_data}, 0);
        check("rst_flags", {done, busy, err, cmd_ready}, 0);

        release_reset(low_cycles);
        check("rst_hold_len", low_cycles, RST_HOLD);
        check("ready_after_rst", cmd_ready, 1);

        run_cmd(OP_COUNT, 9'd5);
        check("count5_n", resq.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("count5_r%0d", i), resq[i], i + 1);
        check("count5_done", done_cnt, 1);
        wait_ready();
        check("count5_ready", cmd_ready, 1);
        check("count5_busy", busy, 0);

        run_cmd(OP_CLEAR, 9'd1);
        check("clear1", resq[0], 0);

        run_cmd(OP_COUNT, 9'd300);
        check("c300_n", resq.size(), 300);
        check("c300_r256", resq[255], 8'h00);
        check("c300_last", resq[299], 8'h2C);
        bad = 0;
        for (int i = 0; i < resq.size(); i++)
            if (resq[i] != 8'((i + 1) % 256)) bad++;
        check("c300_seq", bad, 0);
        check("c300_done", done_cnt, 1);

        run_cmd(OP_CLEAR, 9'd1);
        run_cmd(OP_COUNT, 9'd7);
        check("count7_last", resq[6], 7);
        run_cmd(OP_HOLD, 9'd3);
        check("hold_n", resq.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("hold_r%0d", i), resq[i], 7);
        run_cmd(OP_CLEAR, 9'd2);
        check("clear2_n", resq.size(), 2);
        check("clear2_r0", resq[0], 0);
        check("clear2_r1", resq[1], 0);

        resq.delete();
        done_cnt = 0;
        @(negedge clk);
        issue(OP_COUNT, 9'd10);
        @(negedge clk);
        check("mid_busy", busy, 1);
        check("mid_ready", cmd_ready, 0);
        cmd_op    = OP_CLEAR;
        cmd_len   = 9'd1;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (resq.size() < 2 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("mid_two_results", resq.size() >= 2, 1);
        do_reset();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rails", rails, 0);
        release_reset(low_cycles);
        check("mid_rst_hold", low_cycles, RST_HOLD);
        repeat (10) @(negedge clk);
        check("mid_no_done", done_cnt, 0);
        check("mid_r0", resq[0], 1);
        check("mid_r1", resq[1], 2);
        run_cmd(OP_COUNT, 9'd1);
        check("post_rst_count1", resq[0], 1);

        resq.delete();
        @(negedge clk);
        issue(OP_COUNT, 9'd0);
        check("len0_err", err, 1);
        check("len0_rails", rails, 0);
        check("len0_busy", busy, 0);
        repeat (10) @(negedge clk);
        check("len0_ready", cmd_ready, 0);
        check("len0_no_res", resq.size(), 0);

        do_reset();
        release_reset(low_cycles);
        check("err_cleared", err, 0);
        @(negedge clk);
        issue(OP_RSVD, 9'd4);
        check("rsvd_err", err, 1);
        check("rsvd_rails", rails, 0);

        do_reset();
        release_reset(low_cycles);
        fault_mode = 1'b1;
        resq.delete();
        @(negedge clk);
        issue(OP_COUNT, 9'd3);
        n = 0;
        while (!err && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("fault_err", err, 1);
        check("fault_rails", rails, 0);
        check("fault_ackin", ackin, 1);
        check("fault_busy", busy, 0);
        repeat (10) @(negedge clk);
        check("fault_ready", cmd_ready, 0);
        check("fault_no_res", resq.size(), 0);

        fault_mode = 1'b0;
        do_reset();
        release_reset(low_cycles);
        nodrop_mode = 1'b1;
        @(negedge clk);
        issue(OP_COUNT, 9'd2);
        check("to_data_drive", {t_enable, f_clr}, 2'b11);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1 check("to_not_yet", err, 0);
        @(posedge clk);
        #1 check("to_err", err, 1);
        check("to_rails", rails, 0);

        nodrop_mode = 1'b0;
        do_reset();
        release_reset(low_cycles);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ncl_counter_sequencer.md
NCL_COUNTER_SEQUENCER -- requirements
Module: ncl_counter_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, width of the counter's dual-rail output.
REQ-002 Parameter TIMEOUT, default 1024, handshake watchdog limit in clk cycles.
REQ-003 Parameter RST_HOLD, default 4, clk cycles ncl_reset_n is held low after reset release.
REQ-004 clk  in  1  sequencer clock.
REQ-005 reset  in  1  reset, synchronous, active-low.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; accepted when both high on a clk edge.
REQ-007 cmd_op  in  2  00 COUNT (enable=1, clr=0), 01 HOLD (enable=0, clr=0), 10 CLEAR (clr=1, enable=1), 11 reserved.
REQ-008 cmd_len  in  9  tokens to issue, 1..511; 0 is illegal.
REQ-009 ncl_reset_n  out  1  counter async reset, low true.
REQ-010 f_clr, t_clr, f_enable, t_enable  out  1 each  dual-rail token inputs to the counter.
REQ-011 ackout  in  1  counter input-completion (high = ready for DATA, low = DATA consumed).
REQ-012 ackin  out  1  output acknowledge to counter (high = request DATA, low = request NULL).
REQ-013 f_out, t_out  in  WIDTH each  counter dual-rail result.
REQ-014 res_valid  out  1  one-cycle pulse per captured result; no backpressure.
REQ-015 res_data  out  WIDTH  captured t_out value.
REQ-016 busy, done, err  out  1 each  command active; one-cycle completion pulse; sticky error.

Function
REQ-017 ackout, f_out and t_out SHALL pass through 2-stage synchronizers before any use.
REQ-018 Input FSM: IDLE -> DATA on command accept; DATA drives t_/f_ rails per cmd_op (exactly one rail high per signal) until synced ackout is low; -> NULL drives all four rails low until synced ackout is high; -> DATA if tokens remain, else IDLE.
REQ-019 cmd_ready SHALL be high only in input FSM IDLE with output FSM idle, ncl_reset_n high and err low.
REQ-020 Output FSM: WAIT_DATA (ackin=1) until all bit pairs have exactly one rail high for 2 consecutive synced samples -> capture t_out into res_data, pulse res_valid, drive ackin=0 -> WAIT_NULL until all rails low for 2 consecutive samples -> ackin=1, WAIT_DATA.
REQ-021 Issued and captured token counts SHALL be 9-bit; done pulses the cycle the captured count reaches cmd_len with input FSM in IDLE.
REQ-022 Any synced bit pair with both rails high SHALL set err.
REQ-023 Any handshake phase exceeding TIMEOUT cycles SHALL set err.
REQ-024 cmd_op=11 or cmd_len=0 at accept SHALL set err without issuing tokens.
REQ-025 When err is set, all rails SHALL go low, ackin high, busy low; err clears only on reset.
REQ-026 cmd_valid while busy SHALL be ignored (cmd_ready low).

Reset
REQ-027 While reset is low on a clk edge: both FSMs idle, counts 0, rails 0, ackin 1, ncl_reset_n 0, res_valid 0, res_data 0, done 0, busy 0, err 0.
REQ-028 ncl_reset_n SHALL stay low for RST_HOLD cycles after reset rises, then go high.
REQ-029 Reset mid-command SHALL abandon the command with no done pulse.

Structure
REQ-030 Package ncl_seq_pkg SHALL hold the cmd_op encoding, both FSM state enums and the 2-stage synchronizer depth constant.
REQ-031 Sub-module ncl_sync (parameterized-width 2-flop synchronizer) SHALL be instantiated for ackout and the rail buses.

Verification (bench counter model: COUNT token -> out+1 mod 256, CLEAR -> 0, HOLD -> out unchanged)
REQ-032 Reset, then COUNT len=5 -> res_data 1,2,3,4,5, one done pulse, cmd_ready high after.
REQ-033 COUNT len=300 from 0 -> wrap: 256th result 0x00, last result 0x2C.
REQ-034 HOLD len=3 after count 7 -> three results 7; then CLEAR len=2 -> results 0,0.
REQ-035 Model forces t_out[3]=f_out[3]=1 -> err set, rails all low, cmd_ready low until reset.
REQ-036 Model never drops ackout -> err asserted exactly TIMEOUT cycles after DATA drive.
REQ-037 Reset asserted after 2 tokens of COUNT len=10 -> no done, ncl_reset_n low RST_HOLD cycles after release, next COUNT len=1 -> result 1.
